// File: rtl/add_sub_ripple_carry_pkg.sv
// Shared add/sub opcode encoding for the ALU arithmetic leaves.
// Purely declarative: no logic, no latency, no flow control.
package add_sub_ripple_carry_pkg;

   typedef enum logic {
      OP_SUB = 1'b0,
      OP_ADD = 1'b1
   } op_e;

endpackage

// File: rtl/add_sub_ripple_carry_full_adder.sv
// Single-bit full adder cell, one link of the ripple chain.
// Combinational, zero latency; no backpressure.
module add_sub_ripple_carry_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/add_sub_ripple_carry.sv
// Ripple-carry adder/subtractor; latency 0, or 1 cycle with REGISTER_OUTPUT=1.
// No backpressure: accepts a new operand pair every cycle.
module add_sub_ripple_carry
   import add_sub_ripple_carry_pkg::*;
#(
   parameter int WORD_WIDTH      = 36,
   parameter bit REGISTER_OUTPUT = 1'b0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         add_sub,
   input  logic                         cin,
   input  logic signed [WORD_WIDTH-1:0] dataa,
   input  logic signed [WORD_WIDTH-1:0] datab,
   output logic                         cout,
   output logic        [WORD_WIDTH-1:0] result
);

   logic [WORD_WIDTH-1:0] b_eff;
   logic [WORD_WIDTH-1:0] sum;
   logic [WORD_WIDTH:0]   carry;

   // Subtract is A + ~B + cin, so cin acts as a carry, never a borrow.
   assign b_eff    = (op_e'(add_sub) == OP_ADD) ? datab : ~datab;
   assign carry[0] = cin;

   for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_bit
      add_sub_ripple_carry_full_adder u_fa (
         .a  (dataa[i]),
         .b  (b_eff[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   if (REGISTER_OUTPUT) begin : g_reg
      logic                  cout_q   = 1'b0;
      logic [WORD_WIDTH-1:0] result_q = '0;

      always_ff @(posedge clock) begin
         if (reset) begin
            cout_q   <= 1'b0;
            result_q <= '0;
         end else begin
            cout_q   <= carry[WORD_WIDTH];
            result_q <= sum;
         end
      end

      assign cout   = cout_q;
      assign result = result_q;
   end else begin : g_comb
      // Clock and reset have no role in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clock, reset};

      assign cout   = carry[WORD_WIDTH];
      assign result = sum;
   end

endmodule

// File: tb/tb_add_sub_ripple_carry.sv
// Bench for add_sub_ripple_carry: directed and random checks of widths 1/8/36,
// a 4+4 bit chained pair, and the registered-output build.
module tb_add_sub_ripple_carry;

   int total = 0;
   int bad   = 0;

   logic clock = 1'b0;
   initial forever #5 clock = ~clock;

   // 8-bit combinational
   logic       add8 = 1'b1, cin8 = 1'b0, cout8;
   logic [7:0] a8 = '0, b8 = '0, res8;
   // 1-bit and 36-bit combinational
   logic        add1 = 1'b1, cin1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cout1, res1;
   logic        add36 = 1'b1, cin36 = 1'b0, cout36;
   logic [35:0] a36 = '0, b36 = '0, res36;
   // chained pair of 4-bit instances
   logic       addc = 1'b1, cinc = 1'b0, cout_lo, cout_hi;
   logic [7:0] ac = '0, bc = '0;
   logic [3:0] res_lo, res_hi;
   // registered 8-bit
   logic       r_rst = 1'b1, r_add = 1'b1, r_cin = 1'b0, r_cout;
   logic [7:0] r_a = '0, r_b = '0, r_res;

   add_sub_ripple_carry #(.WORD_WIDTH(8), .REGISTER_OUTPUT(1'b0)) u_w8 (
      .clock(clock), .reset(1'b0), .add_sub(add8), .cin(cin8),
      .dataa(a8), .datab(b8), .cout(cout8), .result(res8));

   add_sub_ripple_carry #(.WORD_WIDTH(1), .REGISTER_OUTPUT(1'b0)) u_w1 (
      .clock(clock), .reset(1'b0), .add_sub(add1), .cin(cin1),
      .dataa(a1), .datab(b1), .cout(cout1), .result(res1));

   add_sub_ripple_carry #(.WORD_WIDTH(36), .REGISTER_OUTPUT(1'b0)) u_w36 (
      .clock(clock), .reset(1'b0), .add_sub(add36), .cin(cin36),
      .dataa(a36), .datab(b36), .cout(cout36), .result(res36));

   add_sub_ripple_carry #(.WORD_WIDTH(4), .REGISTER_OUTPUT(1'b0)) u_lo (
      .clock(clock), .reset(1'b0), .add_sub(addc), .cin(cinc),
      .dataa(ac[3:0]), .datab(bc[3:0]), .cout(cout_lo), .result(res_lo));

   add_sub_ripple_carry #(.WORD_WIDTH(4), .REGISTER_OUTPUT(1'b0)) u_hi (
      .clock(clock), .reset(1'b0), .add_sub(addc), .cin(cout_lo),
      .dataa(ac[7:4]), .datab(bc[7:4]), .cout(cout_hi), .result(res_hi));

   add_sub_ripple_carry #(.WORD_WIDTH(8), .REGISTER_OUTPUT(1'b1)) u_reg (
      .clock(clock), .reset(r_rst), .add_sub(r_add), .cin(r_cin),
      .dataa(r_a), .datab(r_b), .cout(r_cout), .result(r_res));

   // Reference: {cout,result} as an integer of w+1 bits; subtract is A + (2^w-1-B) + cin.
   function automatic logic [63:0] model(int w, logic [63:0] a, logic [63:0] b,
                                         logic add, logic ci);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      a    = a & mask;
      b    = b & mask;
      if (add) return a + b + 64'(ci);
      else     return a + (mask - b) + 64'(ci);
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive8(logic [7:0] a, logic [7:0] b, logic add, logic ci);
      a8 = a; b8 = b; add8 = add; cin8 = ci;
      #1;
   endtask

   task automatic drive_chain(logic [7:0] a, logic [7:0] b, logic add, logic ci);
      ac = a; bc = b; addc = add; cinc = ci;
      #1;
   endtask

   logic [63:0] exp_q;

   initial begin
      // Registered build: power-up and reset
      r_a = 8'hFF; r_b = 8'h01; r_add = 1'b1; r_cin = 1'b0;
      #1;
      check("reg_powerup", 64'({r_cout, r_res}), 64'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reg_reset", 64'({r_cout, r_res}), 64'h0);

      r_rst = 1'b0;
      #1;
      check("reg_hold", 64'({r_cout, r_res}), 64'h0);
      @(negedge clock);
      check("reg_first", 64'({r_cout, r_res}), 64'h100);

      for (int i = 0; i < 20; i++) begin
         r_a = 8'($urandom); r_b = 8'($urandom);
         r_add = 1'($urandom); r_cin = 1'($urandom);
         exp_q = model(8, 64'(r_a), 64'(r_b), r_add, r_cin);
         @(negedge clock);
         check("reg_stream", 64'({r_cout, r_res}), exp_q);
      end

      r_rst = 1'b1; r_a = 8'hFF; r_b = 8'h01; r_add = 1'b1; r_cin = 1'b0;
      @(negedge clock);
      check("reg_mid_reset", 64'({r_cout, r_res}), 64'h0);
      r_rst = 1'b0;
      @(negedge clock);
      check("reg_after_reset", 64'({r_cout, r_res}), 64'h100);

      // 8-bit directed
      drive8(8'h7F, 8'h01, 1'b1, 1'b0); check("add_7f_01", 64'({cout8, res8}), 64'h080);
      drive8(8'h7F, 8'h01, 1'b1, 1'b1); check("add_7f_01_c", 64'({cout8, res8}), 64'h081);
      drive8(8'hFF, 8'h01, 1'b1, 1'b0); check("add_wrap", 64'({cout8, res8}), 64'h100);
      drive8(8'hFF, 8'h00, 1'b1, 1'b1); check("add_ones_cin", 64'({cout8, res8}), 64'h100);
      drive8(8'h05, 8'h03, 1'b0, 1'b1); check("sub_5_3", 64'({cout8, res8}), 64'h102);
      drive8(8'h03, 8'h05, 1'b0, 1'b1); check("sub_3_5", 64'({cout8, res8}), 64'h0FE);
      drive8(8'h05, 8'h03, 1'b0, 1'b0); check("sub_5_3_nc", 64'({cout8, res8}), 64'h101);
      drive8(8'hA5, 8'hA5, 1'b0, 1'b1); check("sub_equal", 64'({cout8, res8}), 64'h100);

      // Chained 4+4
      drive_chain(8'h38, 8'h19, 1'b1, 1'b0);
      check("chain_add", 64'({cout_hi, res_hi, res_lo}), 64'h051);
      drive_chain(8'h10, 8'h01, 1'b0, 1'b1);
      check("chain_sub", 64'({cout_hi, res_hi, res_lo}), 64'h10F);

      // Random vectors across all combinational builds
      for (int i = 0; i < 10000; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); add8 = 1'($urandom); cin8 = 1'($urandom);
         a1 = 1'($urandom); b1 = 1'($urandom); add1 = 1'($urandom); cin1 = 1'($urandom);
         a36 = 36'({$urandom, $urandom}); b36 = 36'({$urandom, $urandom});
         add36 = 1'($urandom); cin36 = 1'($urandom);
         ac = 8'($urandom); bc = 8'($urandom); addc = 1'($urandom); cinc = 1'($urandom);
         #1;
         check("rand_w8", 64'({cout8, res8}), model(8, 64'(a8), 64'(b8), add8, cin8));
         check("rand_w1", 64'({cout1, res1}), model(1, 64'(a1), 64'(b1), add1, cin1));
         check("rand_w36", 64'({cout36, res36}), model(36, 64'(a36), 64'(b36), add36, cin36));
         check("rand_chain", 64'({cout_hi, res_hi, res_lo}),
               model(8, 64'(ac), 64'(bc), addc, cinc));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_sub_ripple_carry.md
Name: add_sub_ripple_carry

Overview:
Parameterised ripple-carry adder/subtractor with carry-in and carry-out. It is the leaf arithmetic element of the ALU. Pipelined wrappers split a word into halves and chain one instance's cout into the next instance's cin. The default build is purely combinational; an optional output register stage exists for standalone timing closure.

Parameters:
WORD_WIDTH, 36, operand and result width in bits; must be >= 1 (wrappers use WORD_WIDTH/2 per half).
REGISTER_OUTPUT, 0, 0 = combinational outputs; 1 = cout/result registered (1-cycle latency).

Ports:
clock  input  1  system clock; used only when REGISTER_OUTPUT=1.
reset  input  1  synchronous, active-high; clears the output registers when REGISTER_OUTPUT=1; ignored otherwise.
add_sub  input  1  1 = add, 0 = subtract.
cin  input  1  carry-in to bit 0, as a carry, not a borrow.
dataa  input  WORD_WIDTH  operand A (signed-declared; treated bitwise).
datab  input  WORD_WIDTH  operand B (signed-declared; treated bitwise).
cout  output  1  carry out of bit WORD_WIDTH-1.
result  output  WORD_WIDTH  sum/difference, modulo 2^WORD_WIDTH.

Behaviour:
- Effective B operand: b_eff = add_sub ? datab : ~datab (bitwise invert).
- Arithmetic: {cout, result} = dataa + b_eff + cin, evaluated at WORD_WIDTH+1 bits with zero-extended operands.
- Add (add_sub=1): result = A+B+cin.
- Subtract (add_sub=0): result = A-B-1+cin.
  - True A-B requires cin=1.
  - cout=1 means no borrow (A >= B unsigned when cin=1).
- No overflow flag. Signed overflow is the caller's concern; wrap-around is silent.
- Carry rules:
  - Carry ripples bit 0 to MSB: c[0]=cin, s[i]=a[i]^b_eff[i]^c[i], c[i+1]=majority(a[i],b_eff[i],c[i]), cout=c[WORD_WIDTH].
  - No carry-lookahead; the synthesis tool maps the chain to device carry logic.
- Chaining two instances (lower cout -> upper cin, same add_sub) yields an exact 2*WORD_WIDTH add/sub. Cross-width chaining correctness is required.
- REGISTER_OUTPUT=0:
  - Outputs change combinationally with any input.
  - No state; clock and reset have no effect.
- REGISTER_OUTPUT=1:
  - cout/result capture the combinational value on the rising clock edge (latency 1, throughput 1/cycle).
  - Reset asserted at an edge forces cout=0 and result=0, overriding inputs.
  - After deassertion, the first valid output appears one edge after inputs are applied.
  - Power-up/initial value of the registers is 0.
- All-ones boundary: A=all-ones, B=0, cin=1, add gives result=0, cout=1.
- Subtract of equal operands with cin=1 gives result=0, cout=1.

Decomposition:
- No shared package needed. WORD_WIDTH is a parameter only; the add/sub encoding (1=add) may be a localparam shared via the ALU package if one exists.
- One natural sub-module: full_adder (a, b, ci -> s, co), generated WORD_WIDTH times to form the ripple chain.
- Output register is an inline generate block, not a sub-module.

Test Plan:
All scenarios use WORD_WIDTH=8, REGISTER_OUTPUT=0 unless noted.
- Add: A=0x7F, B=0x01, cin=0, add_sub=1 -> result=0x80, cout=0. Same operands with cin=1 -> 0x81, cout=0.
- Add wrap: A=0xFF, B=0x01, cin=0, add_sub=1 -> result=0x00, cout=1. A=0xFF, B=0x00, cin=1 -> 0x00, cout=1.
- Subtract: A=0x05, B=0x03, cin=1, add_sub=0 -> 0x02, cout=1. A=0x03, B=0x05, cin=1 -> 0xFE, cout=0. A=0x05, B=0x03, cin=0 -> 0x01, cout=1.
- Chaining: two 4-bit instances, lower cout -> upper cin.
  - A=0x38, B=0x19, add, cin=0 -> combined 0x51, upper cout=0.
  - A=0x10, B=0x01, subtract, cin=1 -> combined 0x0F, cout=1.
- Random: 10k random A/B/cin/add_sub vectors at WORD_WIDTH=1, 8 and 36 -> match the {cout,result} reference formula exactly.
- Registered (REGISTER_OUTPUT=1):
  - reset=1 for 2 cycles -> cout=0, result=0.
  - Release reset, apply A=0xFF, B=0x01, add -> outputs unchanged until the next edge, then 0x00/cout=1.
  - Assert reset mid-stream -> outputs 0 at the following edge.
